spi_cmd_sequencer: RTL and testbench

//  Packet controller for the 8-bit SPI slave FIFO datapath. Pops command/address/length bytes from the RX FIFO and

---
 rtl/spi_cmd_sequencer.sv | 128 ++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: turns CMD/ADDR/LEN framed SPI FIFO bytes into req/ack register bus bursts.
module spi_cmd_sequencer #(
  parameter logic [7:0] CMD_WRITE   = 8'h01,
  parameter logic [7:0] CMD_READ    = 8'h02,
  parameter int         BUS_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       bus_req,
  output logic       bus_we,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_ack,
  output logic       busy,
  output logic       err,
  output logic       abort
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_WR_DATA, S_WR_BUS, S_RD, S_FLUSH} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_addr, r_len, r_cnt, r_drop, r_wdata, r_txd, r_tmo;
  logic       r_wr, r_req, r_txv, r_err, r_abort;
  logic       w_pop, w_abort, w_cmd_ok, w_tmo, w_done, w_push, w_rd_done;
  assign w_pop     = rx_valid && rx_ready;
  assign w_abort   = cs_n && r_state != S_IDLE && r_state != S_FLUSH;
  assign w_cmd_ok  = rx_data == CMD_WRITE || rx_data == CMD_READ;
  assign w_tmo     = r_req && !bus_ack && r_tmo == 8'(BUS_TIMEOUT - 1);
  assign w_done    = r_req && (bus_ack || w_tmo);
  assign w_push    = r_txv && tx_ready;
  assign w_rd_done = r_cnt == r_len && r_drop == r_len && !r_txv && !r_req;
  assign bus_req   = r_req;
  assign bus_we    = r_req && r_wr;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign tx_data   = r_txd;
  assign tx_valid  = r_txv;
  assign err       = r_err;
  assign abort     = r_abort;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_abort) w_next = S_FLUSH;
    else case (r_state)
      S_IDLE:    if (w_pop && w_cmd_ok) w_next = S_ADDR;
      S_ADDR:    if (w_pop) w_next = S_LEN;
      S_LEN:     if (w_pop) w_next = (rx_data == 8'd0) ? S_IDLE : r_wr ? S_WR_DATA : S_RD;
      S_WR_DATA: if (w_pop) w_next = S_WR_BUS;
      S_WR_BUS:  if (w_done) w_next = (8'(r_cnt + 8'd1) < r_len) ? S_WR_DATA : S_IDLE;
      S_RD:      if (w_rd_done) w_next = S_IDLE;
      S_FLUSH:   if (!rx_valid) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end
  // rx_ready is held low during reset so every output reads 0 there
  always_comb begin
    rx_ready = !rst && ((r_state == S_RD) ? (r_drop < r_len) : (r_state != S_WR_BUS));
    busy     = r_state != S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= 8'd0;
      r_len   <= 8'd0;
      r_cnt   <= 8'd0;
      r_drop  <= 8'd0;
      r_wdata <= 8'd0;
      r_txd   <= 8'd0;
      r_tmo   <= 8'd0;
      r_wr    <= 1'b0;
      r_req   <= 1'b0;
      r_txv   <= 1'b0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_err   <= 1'b0;
      r_abort <= w_abort;
      r_tmo   <= (r_req && !bus_ack && !w_tmo) ? r_tmo + 8'd1 : 8'd0;
      if (w_abort) begin
        r_req <= 1'b0;
        r_txv <= 1'b0;
      end else begin
        // a timed-out access completes like an ack: reads return 0xFF, writes are dropped
        if (w_done) begin
          r_req  <= 1'b0;
          r_err  <= w_tmo;
          r_addr <= r_addr + 8'd1;
          r_cnt  <= r_cnt + 8'd1;
          if (!r_wr) begin
            r_txv <= 1'b1;
            r_txd <= bus_ack ? bus_rdata : 8'hFF;
          end
        end
        if (w_push) begin
          r_txv <= 1'b0;
          r_req <= r_cnt < r_len;
        end
        if (w_pop) case (r_state)
          S_IDLE: begin
            if (w_cmd_ok) r_wr <= rx_data == CMD_WRITE;
            else          r_err <= 1'b1;
          end
          S_ADDR: r_addr <= rx_data;
          S_LEN: begin
            r_len  <= rx_data;
            r_cnt  <= 8'd0;
            r_drop <= 8'd0;
            r_req  <= rx_data != 8'd0 && !r_wr;
          end
          S_WR_DATA: begin
            r_wdata <= rx_data;
            r_req   <= 1'b1;
          end
          S_RD:    r_drop <= r_drop + 8'd1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: frame-level model feeds expected bus/TX queues; monitors pop and compare.
`timescale 1ns/1ps
module tb_spi_cmd_sequencer;
  localparam int TO = 99;
  localparam logic [7:0] CMD_W = 8'h01;
  localparam logic [7:0] CMD_R = 8'h02;
  logic clk = 1'b0;
  logic rst, cs_n, rx_valid, rx_ready, tx_valid, tx_ready, bus_req, bus_we, bus_ack, busy, err, abort;
  logic [7:0] rx_data, tx_data, bus_addr, bus_wdata, bus_rdata;
  always #5 clk = ~clk;

  spi_cmd_sequencer #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy), .err(err), .abort(abort)
  );

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    int         lat;
  } bus_t;
  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$], rx_q[$], dq[$];
  int n_chk = 0, n_pass = 0, n_err = 0, exp_err = 0, n_abort = 0, exp_abort = 0, n_push = 0;
  bit tx_hold = 0, tx_rand = 0, run = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // RX FIFO model
  initial begin
    bit fire;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      fire = rx_valid && rx_ready;
      @(posedge clk);
      #1;
      if (fire) void'(rx_q.pop_front());
      rx_valid = rx_q.size() != 0;
      rx_data  = rx_valid ? rx_q[0] : 8'h00;
    end
  end

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = tx_hold ? 1'b0 : tx_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // bus responder + access checker
  initial begin
    bus_t e;
    bit   ok;
    bus_ack   = 1'b0;
    bus_rdata = 8'h00;
    wait (run);
    forever begin
      @(negedge clk);
      if (bus_req) begin
        if (exp_bus.size() == 0) begin
          chk(1'b0, "bus_unexpected", int'(bus_addr), 0);
          for (int k = 0; k < 8 && bus_req; k++) @(negedge clk);
        end else begin
          e = exp_bus.pop_front();
          chk(bus_addr == e.addr && bus_we == e.we && (!e.we || bus_wdata == e.wdata), "bus_access",
              int'({bus_we, bus_addr, bus_wdata}), int'({e.we, e.addr, e.wdata}));
          if (e.lat == TO) begin
            ok = 1'b1;
            for (int k = 1; k <= 4; k++) begin
              @(negedge clk);
              ok = ok && ((k < 4) ? (bus_req && !err) : (!bus_req && err));
            end
            chk(ok, "timeout_err", int'({bus_req, err}), 1);
          end else begin
            repeat (e.lat) @(posedge clk);
            #1;
            bus_ack   = 1'b1;
            bus_rdata = e.addr ^ 8'h55;
            @(posedge clk);
            #1;
            bus_ack = 1'b0;
          end
        end
      end
    end
  end

  // TX monitor, hold checker, pulse counters
  initial begin
    logic pv, pr;
    logic [7:0] pd, e;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    wait (run);
    forever begin
      @(negedge clk);
      if (err) n_err++;
      if (abort) n_abort++;
      if (pv && !pr && !abort)
        chk(tx_valid && tx_data == pd, "tx_hold", int'({tx_valid, tx_data}), int'({1'b1, pd}));
      if (tx_valid && tx_ready) begin
        n_push++;
        if (exp_tx.size() == 0) chk(1'b0, "tx_unexpected", int'(tx_data), 0);
        else begin
          e = exp_tx.pop_front();
          chk(tx_data == e, "tx_data", int'(tx_data), int'(e));
        end
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end
  end

  // reference model: one frame -> RX bytes, expected bus accesses, expected TX bytes
  task automatic frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] l,
                       input int lat, input bit to_first);
    bus_t e;
    int   lt;
    rx_q.push_back(cmd);
    if (cmd != CMD_W && cmd != CMD_R) begin
      exp_err++;
      return;
    end
    rx_q.push_back(a);
    rx_q.push_back(l);
    for (int i = 0; i < int'(l); i++) begin
      lt = (to_first && i == 0) ? TO : (lat > 0) ? lat :
           ($urandom_range(0, 5) == 0) ? TO : int'($urandom_range(1, 3));
      if (lt == TO) exp_err++;
      e.addr = a + 8'(i);
      e.we   = cmd == CMD_W;
      e.lat  = lt;
      e.wdata = 8'h00;
      if (cmd == CMD_W) begin
        e.wdata = (dq.size() != 0) ? dq.pop_front() : 8'($urandom);
        rx_q.push_back(e.wdata);
      end else exp_tx.push_back(lt == TO ? 8'hFF : e.addr ^ 8'h55);
      exp_bus.push_back(e);
    end
    if (cmd == CMD_R)
      for (int i = 0; i < int'(l); i++) begin
        repeat (6) @(posedge clk);
        rx_q.push_back(8'($urandom));
      end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((rx_q.size() != 0 || exp_bus.size() != 0 || exp_tx.size() != 0 || busy || rx_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(t < 3000, name, t, 3000);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    logic [7:0] d;
    bit ok;
    rst  = 1'b1;
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({rx_ready, tx_valid, tx_data, bus_req, bus_we, bus_addr, bus_wdata, busy, err, abort} == 31'd0,
        "reset_outputs", int'({rx_ready, tx_valid, tx_data, bus_req, bus_we, bus_addr, bus_wdata, busy, err, abort}), 0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    cs_n = 1'b0;
    run  = 1'b1;
    // write burst
    dq.push_back(8'hAA);
    dq.push_back(8'hBB);
    frame(CMD_W, 8'h10, 8'd2, 1, 1'b0);
    wait_idle("write_done");
    // read with address wrap
    frame(CMD_R, 8'hFE, 8'd3, 1, 1'b0);
    wait_idle("read_wrap_done");
    chk(rx_q.size() == 0, "read_rx_emptied", rx_q.size(), 0);
    // zero length, unknown command, then a single write
    frame(CMD_R, 8'h20, 8'd0, 1, 1'b0);
    frame(8'h7F, 8'h00, 8'd0, 1, 1'b0);
    frame(CMD_W, 8'h30, 8'd1, 1, 1'b0);
    wait_idle("len0_unknown_done");
    chk(n_err == exp_err, "unknown_cmd_err", n_err, exp_err);
    // first read access times out
    frame(CMD_R, 8'h40, 8'd2, 1, 1'b1);
    wait_idle("timeout_done");
    chk(n_err == exp_err, "timeout_err_count", n_err, exp_err);
    // abort mid write burst
    begin
      bus_t e;
      e.addr = 8'h40; e.we = 1'b1; e.wdata = 8'hD0; e.lat = 5;
      exp_bus.push_back(e);
      rx_q.push_back(CMD_W); rx_q.push_back(8'h40); rx_q.push_back(8'h04);
      rx_q.push_back(8'hD0); rx_q.push_back(8'hD1); rx_q.push_back(8'hD2); rx_q.push_back(8'hD3);
      t = 0;
      while (!bus_req && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk(bus_req, "abort_req_seen", int'(bus_req), 1);
      @(posedge clk);
      #1;
      cs_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk(abort && !bus_req && !tx_valid, "abort_pulse", int'({abort, bus_req, tx_valid}), 4);
      exp_abort++;
      wait_idle("abort_flush");
      @(posedge clk);
      #1;
      cs_n = 1'b0;
    end
    // TX back-pressure on the second read byte
    fork
      frame(CMD_R, 8'h50, 8'd3, 1, 1'b0);
      begin : stall
        int p0, s;
        p0 = n_push;
        s  = 0;
        while (n_push == p0 && s < 200) begin
          @(negedge clk);
          s++;
        end
        tx_hold = 1'b1;
        @(negedge clk);
        s = 0;
        while (!tx_valid && s < 50) begin
          @(negedge clk);
          s++;
        end
        chk(tx_valid, "stall_valid", int'(tx_valid), 1);
        d  = tx_data;
        ok = 1'b1;
        repeat (10) begin
          @(negedge clk);
          ok = ok && tx_valid && tx_data == d && !bus_req;
        end
        chk(ok, "stall_hold_no_req", int'({tx_valid, bus_req, tx_data}), int'({2'b10, d}));
        tx_hold = 1'b0;
      end
    join
    wait_idle("stall_done");
    // randomised frames with random bus latency, timeouts and TX back-pressure
    tx_rand = 1'b1;
    for (int f = 0; f < 24; f++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k == 0) frame(8'($urandom_range(3, 255)), 8'h00, 8'd0, 0, 1'b0);
      else frame((k < 5) ? CMD_W : CMD_R, (k == 4 || k == 9) ? 8'hFD : 8'($urandom),
                 8'($urandom_range(0, 5)), 0, 1'b0);
    end
    wait_idle("random_drain");
    chk(n_err == exp_err, "err_count", n_err, exp_err);
    chk(n_abort == exp_abort, "abort_count", n_abort, exp_abort);
    chk(rx_q.size() == 0 && !busy, "final_idle", int'({busy, rx_q.size() != 0}), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
